rx_block_sync: RTL and testbench

- RX gearbox and block aligner between the SERDES parallel RX word and the lock state machine.
- Accumulates a DATA_WIDTH-bit bitstream into 66-bit blocks.
- Presents each block as a 2-bit sync header plus a 64-bit payload, with a one-cycle valid strobe.
- Honours one-bit slip requests from the lock state machine so block alignment can be hunted.

---
 rtl/rx_block_sync.sv | 81 ++++++++
 tb/tb_rx_block_sync.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_block_sync.sv
// RX gearbox / block aligner: packs DATA_WIDTH-bit SERDES words into 66-bit blocks (2-bit header + 64-bit payload).
// Define RX_BLOCK_SYNC_SLIP_CNT_EN to add the saturating o_slip_count output.
module rx_block_sync #(
   parameter int DATA_WIDTH    = 32,
   parameter int HDR_WIDTH     = 2,
   parameter int PAYLOAD_WIDTH = 64
) (
   input  logic                     i_clk,
   input  logic                     i_reset_n,
   input  logic [DATA_WIDTH-1:0]    i_data,
   input  logic                     i_data_valid,
   input  logic                     i_slip,
   output logic [HDR_WIDTH-1:0]     o_hdr,
   output logic [PAYLOAD_WIDTH-1:0] o_data,
   output logic                     o_hdr_valid
`ifdef RX_BLOCK_SYNC_SLIP_CNT_EN
   ,
   output logic [15:0]              o_slip_count
`endif
);

   localparam int BLK   = HDR_WIDTH + PAYLOAD_WIDTH;
   localparam int BUF_W = BLK + 2 * DATA_WIDTH;
   localparam int CNT_W = $clog2(BUF_W) + 1;

   logic [BUF_W-1:0] bit_buf_q, bit_buf_d, shifted, appended;
   logic [CNT_W-1:0] cnt_q, cnt_d, need, base;
   logic [BLK-1:0]   win;
   logic             slip_pending_q, slip_pending_d;
   logic             emit, slip_set;

   always_comb begin
      need           = CNT_W'(BLK) + {{(CNT_W-1){1'b0}}, slip_pending_q};
      emit           = (cnt_q >= need);
      slip_set       = i_slip & ~slip_pending_q;
      // A pending slip discards buf[0], so the block window starts one bit higher.
      win            = slip_pending_q ? bit_buf_q[BLK:1] : bit_buf_q[BLK-1:0];
      shifted        = emit ? (bit_buf_q >> need) : bit_buf_q;
      base           = emit ? (cnt_q - need) : cnt_q;
      appended       = BUF_W'(i_data) << base;
      bit_buf_d      = shifted;
      cnt_d          = base;
      if (i_data_valid) begin
         // Bits at and above cnt are always zero, so an OR merges the new word.
         bit_buf_d = shifted | appended;
         cnt_d     = base + CNT_W'(DATA_WIDTH);
      end
      slip_pending_d = slip_set | (slip_pending_q & ~emit);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         bit_buf_q      <= '0;
         cnt_q          <= '0;
         slip_pending_q <= 1'b0;
         o_hdr          <= '0;
         o_data         <= '0;
         o_hdr_valid    <= 1'b0;
      end else begin
         bit_buf_q      <= bit_buf_d;
         cnt_q          <= cnt_d;
         slip_pending_q <= slip_pending_d;
         o_hdr_valid    <= emit;
         if (emit) begin
            o_hdr  <= win[HDR_WIDTH-1:0];
            o_data <= win[BLK-1:HDR_WIDTH];
         end
      end
   end

`ifdef RX_BLOCK_SYNC_SLIP_CNT_EN
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_slip_count <= '0;
      end else if (slip_set && (o_slip_count != '1)) begin
         o_slip_count <= o_slip_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rx_block_sync.sv
// Self-checking bench for rx_block_sync: table vectors, directed corner sequences and a
// bit-queue reference model under randomized traffic; also a DATA_WIDTH=64 instance.
module tb_rx_block_sync;

   localparam logic [63:0] PAYLOAD = 64'h0123_4567_89AB_CDEF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] d32 = '0;
   logic        v32 = 1'b0, s32 = 1'b0;
   logic [1:0]  h32;
   logic [63:0] o32;
   logic        hv32;
   logic        rst64 = 1'b0;
   logic [63:0] d64 = '0;
   logic        v64 = 1'b0, s64 = 1'b0;
   logic [1:0]  h64;
   logic [63:0] o64;
   logic        hv64;
`ifdef RX_BLOCK_SYNC_SLIP_CNT_EN
   logic [15:0] sc32, sc64;
`endif

   always #5 clk = ~clk;

   rx_block_sync #(.DATA_WIDTH(32), .HDR_WIDTH(2), .PAYLOAD_WIDTH(64)) u32 (
      .i_clk(clk), .i_reset_n(rst_n), .i_data(d32), .i_data_valid(v32), .i_slip(s32),
      .o_hdr(h32), .o_data(o32), .o_hdr_valid(hv32)
`ifdef RX_BLOCK_SYNC_SLIP_CNT_EN
      , .o_slip_count(sc32)
`endif
   );

   rx_block_sync #(.DATA_WIDTH(64), .HDR_WIDTH(2), .PAYLOAD_WIDTH(64)) u64 (
      .i_clk(clk), .i_reset_n(rst64), .i_data(d64), .i_data_valid(v64), .i_slip(s64),
      .o_hdr(h64), .o_data(o64), .o_hdr_valid(hv64)
`ifdef RX_BLOCK_SYNC_SLIP_CNT_EN
      , .o_slip_count(sc64)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Transmit side: bit queue feeding DUT words, refilled according to mode.
   bit          src[$];
   int          mode;
   logic [65:0] cblk;

   // Reference model: queue of received, unconsumed bits.
   bit          mq[$];
   bit          m_pend;
   logic [1:0]  e_hdr;
   logic [63:0] e_data;
   logic        e_valid;
   logic [15:0] m_scount;

   int cyc, strobes, win_strobes, consec;
   bit prev_hv;

   typedef struct {
      bit         v;
      bit         s;
      bit         ev;
      logic [1:0] eh;
   } vec_t;
   vec_t vec[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic refill();
      logic [1:0]  hh;
      logic [63:0] pp;
      case (mode)
         0: for (int i = 0; i < 66; i++) src.push_back(cblk[i]);
         1: begin
            hh = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            pp = {$urandom, $urandom};
            for (int i = 0; i < 2; i++) src.push_back(hh[i]);
            for (int i = 0; i < 64; i++) src.push_back(pp[i]);
         end
         default: for (int i = 0; i < 32; i++) src.push_back(bit'($urandom_range(0, 1)));
      endcase
   endtask

   task automatic edge32(input bit v, input bit s);
      logic [31:0] w;
      bit pend_old, emit;
      w = $urandom;
      if (v) begin
         for (int i = 0; i < 32; i++) begin
            if (src.size() == 0) refill();
            w[i] = src.pop_front();
         end
      end
      d32 = w; v32 = v; s32 = s;
      @(posedge clk);
      pend_old = m_pend;
      emit     = (mq.size() >= (pend_old ? 67 : 66));
      e_valid  = emit;
      if (emit) begin
         if (pend_old) void'(mq.pop_front());
         for (int i = 0; i < 2; i++) e_hdr[i] = mq.pop_front();
         for (int i = 0; i < 64; i++) e_data[i] = mq.pop_front();
      end
      if (s && !pend_old && m_scount != 16'hFFFF) m_scount++;
      m_pend = (s && !pend_old) || (pend_old && !emit);
      if (v) for (int i = 0; i < 32; i++) mq.push_back(w[i]);
      cyc++;
      #1;
      chk("hdr_valid", 64'(hv32), 64'(e_valid));
      chk("hdr", 64'(h32), 64'(e_hdr));
      chk("data", o32, e_data);
      chk("cnt_bound", 64'(u32.cnt_q <= 130), 64'd1);
`ifdef RX_BLOCK_SYNC_SLIP_CNT_EN
      chk("slip_count", 64'(sc32), 64'(m_scount));
`endif
      if (hv32 && prev_hv) consec++;
      prev_hv = hv32;
      if (hv32) strobes++;
      if (hv32 && cyc >= 4 && cyc <= 36) win_strobes++;
   endtask

   task automatic model_clear();
      mq.delete(); src.delete();
      m_pend = 0; e_hdr = '0; e_data = '0; e_valid = 1'b0; m_scount = '0;
      cyc = 0; strobes = 0; win_strobes = 0; consec = 0; prev_hv = 0;
   endtask

   // Asserts reset away from the clock edge and checks the outputs clear at once.
   task automatic do_reset();
      rst_n = 1'b0; v32 = 1'b0; s32 = 1'b0;
      #1;
      chk("rst_valid", 64'(hv32), 64'd0);
      chk("rst_hdr", 64'(h32), 64'd0);
      chk("rst_data", o32, 64'd0);
`ifdef RX_BLOCK_SYNC_SLIP_CNT_EN
      chk("rst_slip_count", 64'(sc32), 64'd0);
`endif
      model_clear();
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [63:0] sh_data;
      logic [63:0] w;
      int          slips, good, total, n64, p;
      bit          req, found;

      cblk    = {PAYLOAD, 2'b01};
      sh_data = {1'b1, PAYLOAD[63:1]};
      mode    = 0;

      vec[0] = '{1, 0, 0, 2'b00};
      vec[1] = '{1, 0, 0, 2'b00};
      vec[2] = '{1, 0, 0, 2'b00};
      vec[3] = '{1, 0, 1, 2'b01};
      vec[4] = '{1, 0, 0, 2'b01};
      vec[5] = '{1, 0, 1, 2'b01};
      vec[6] = '{1, 0, 0, 2'b01};
      vec[7] = '{1, 0, 1, 2'b01};
      vec[8] = '{1, 0, 0, 2'b01};
      vec[9] = '{1, 0, 1, 2'b01};

      // Aligned stream: latency table then throughput window edges 4..36.
      mode = 0;
      do_reset();
      for (int k = 0; k < 10; k++) begin
         edge32(vec[k].v, vec[k].s);
         chk("tbl_valid", 64'(hv32), 64'(vec[k].ev));
         if (vec[k].ev) begin
            chk("tbl_hdr", 64'(h32), 64'(vec[k].eh));
            chk("tbl_data", o32, PAYLOAD);
         end
      end
      for (int k = 10; k < 36; k++) edge32(1, 0);
      chk("thru32", 64'(win_strobes), 64'd16);
      chk("no_back_to_back", 64'(consec), 64'd0);

      // Slip on an emitting edge, plus an absorbed second pulse.
      do_reset();
      for (int k = 0; k < 5; k++) edge32(1, 0);
      edge32(1, 1);
      chk("slip_same_edge_valid", 64'(hv32), 64'd1);
      chk("slip_same_edge_hdr", 64'(h32), 64'(2'b01));
      chk("slip_same_edge_data", o32, PAYLOAD);
      edge32(1, 1);
      chk("slip_gap_valid", 64'(hv32), 64'd0);
      edge32(1, 0);
      chk("slipped_valid", 64'(hv32), 64'd1);
      chk("slipped_hdr", 64'(h32), 64'(2'b10));
      chk("slipped_data", o32, sh_data);
      edge32(1, 0);
      edge32(1, 0);
      chk("one_bit_only_hdr", 64'(h32), 64'(2'b10));
      chk("one_bit_only_data", o32, sh_data);
`ifdef RX_BLOCK_SYNC_SLIP_CNT_EN
      chk("absorbed_count", 64'(sc32), 64'd1);
`endif

      // Valid toggled every cycle, then drained.
      do_reset();
      total = 0;
      for (int k = 0; k < 80; k++) begin
         edge32(k % 2 == 0, 0);
         if (k % 2 == 0) total += 32;
         if (hv32) begin
            chk("toggle_hdr", 64'(h32), 64'(2'b01));
            chk("toggle_data", o32, PAYLOAD);
         end
      end
      for (int k = 0; k < 10; k++) edge32(0, 0);
      chk("toggle_blocks", 64'(strobes), 64'(total / 66));

      // Reset mid-block with 40 bits buffered.
      do_reset();
      found = 0;
      for (int k = 0; k < 60 && !found; k++) begin
         edge32(1, 0);
         if (mq.size() == 40) found = 1;
      end
      chk("reach_cnt40", 64'(found), 64'd1);
      do_reset();
      for (int k = 1; k <= 6; k++) begin
         edge32(1, 0);
         if (k == 4) begin
            chk("post_rst_valid", 64'(hv32), 64'd1);
            chk("post_rst_hdr", 64'(h32), 64'(2'b01));
            chk("post_rst_data", o32, PAYLOAD);
         end
      end

      // Misaligned by 5 junk bits; bench slips on every bad header.
      do_reset();
      mode = 1;
      for (int i = 0; i < 5; i++) src.push_back(1'b0);
      slips = 0; good = 0; req = 0;
      for (int k = 0; k < 4000 && good < 64; k++) begin
         edge32(1, req);
         req = 0;
         if (hv32) begin
            if (h32 == 2'b00 || h32 == 2'b11) begin
               req = 1; slips++; good = 0;
            end else begin
               good++;
            end
         end
      end
      chk("lock_reached", 64'(good >= 64), 64'd1);
      chk("slips", 64'(slips), 64'd5);
`ifdef RX_BLOCK_SYNC_SLIP_CNT_EN
      chk("slip_count_5", 64'(sc32), 64'd5);
`endif

      // Randomized traffic against the model.
      do_reset();
      mode = 2;
      for (int k = 0; k < 2000; k++) edge32($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);

      // DATA_WIDTH=64 instance, aligned stream.
      #2 rst64 = 1'b1;
      n64 = 0; p = 0;
      for (int e = 1; e <= 36; e++) begin
         for (int j = 0; j < 64; j++) w[j] = cblk[(p + j) % 66];
         p = (p + 64) % 66;
         d64 = w; v64 = 1'b1; s64 = 1'b0;
         @(posedge clk);
         #1;
         if (e <= 2) chk("lat64_idle", 64'(hv64), 64'd0);
         if (e == 3) chk("lat64_first", 64'(hv64), 64'd1);
         if (hv64) begin
            chk("hdr64", 64'(h64), 64'(2'b01));
            chk("data64", o64, PAYLOAD);
         end
         if (hv64 && e >= 3 && e <= 35) n64++;
      end
      chk("thru64", 64'(n64), 64'd32);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
